// File: rtl/stream_mux_n_if.sv
// Handshake bundle for stream_mux_n: per-channel valid/ready/data inputs, channel select,
// and the single registered output stream.
interface stream_mux_n_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel stream multiplexer into a one-entry output register.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise the channel comes from sel.
module stream_mux_n #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst,
    stream_mux_n_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] chan_q, chan_d;

    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             can_load;
    logic             xfer;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             unused_sel;

    assign unused_sel = ^bus.sel;

    // Scan from the highest offset down so the first valid channel at or after ptr wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(CHANNELS)) idx = idx - int'(CHANNELS);
            if (bus.in_valid[SEL_W'(idx)]) begin
                grant_valid = 1'b1;
                grant       = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (32'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        grant       = bus.sel;
        grant_valid = 1'b0;
        if (32'(bus.sel) < CHANNELS) grant_valid = bus.in_valid[bus.sel];
    end
`endif

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (grant == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign can_load = (state_q == StEmpty) || bus.out_ready;
    assign xfer     = !rst && can_load && grant_valid;

    always_comb begin
        bus.in_ready = '0;
        state_d      = state_q;
        data_d       = data_q;
        chan_d       = chan_q;
        if (xfer) begin
            bus.in_ready[grant] = 1'b1;
            state_d             = StFull;
            data_d              = grant_data;
            chan_d              = grant;
        end else if (state_q == StFull && bus.out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign bus.out_valid = (state_q == StFull);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n: directed scenarios then random traffic against a
// transaction-level model (grant rule + word queue).
module tb_stream_mux_n;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    stream_mux_n_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    stream_mux_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: output register contents, RR pointer and words awaiting drain.
    bit         m_full = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_chan = 2'd0;
    int         m_ptr  = 0;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Granted channel per mode rule, or -1 when none.
    function automatic int model_grant();
`ifdef STREAM_MUX_RR_EN
        for (int k = 0; k < 4; k++) begin
            int i = (m_ptr + k) % 4;
            if (bus.in_valid[2'(i)]) return i;
        end
        return -1;
`else
        if (int'(bus.sel) < 4 && bus.in_valid[bus.sel]) return int'(bus.sel);
        return -1;
`endif
    endfunction

    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic [1:0] s, input logic o);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.sel       = s;
        bus.out_ready = o;
    endtask

    task automatic cycle();
        int         g;
        bit         load_ok;
        logic [3:0] exp_ready;
        logic [7:0] word;
        @(negedge clk);
        g         = model_grant();
        load_ok   = !m_full || bus.out_ready;
        exp_ready = (!rst && load_ok && g >= 0) ? 4'(1 << g) : 4'h0;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("out_valid_sb", 32'(bus.out_valid), 32'(sb.size() > 0));
        if (!rst && m_full && bus.out_ready && sb.size() > 0)
            check("drain_word", 32'(bus.out_data), 32'(sb[0]));
        @(posedge clk);
        if (rst) begin
            m_full = 1'b0;
            m_data = 8'h00;
            m_chan = 2'd0;
            m_ptr  = 0;
            sb.delete();
        end else begin
            if (m_full && bus.out_ready) begin
                word   = sb.pop_front();
                m_full = 1'b0;
            end
            if (load_ok && g >= 0) begin
                word   = bus.in_data[g*8 +: 8];
                sb.push_back(word);
                m_full = 1'b1;
                m_data = word;
                m_chan = 2'(g);
                m_ptr  = (g + 1) % 4;
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_full));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_chan", 32'(bus.out_chan), 32'(m_chan));
    endtask

    initial begin
        drive(1'b1, 4'hF, 32'h0, 2'd0, 1'b0);
        cycle();
        cycle();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h00);
        check("rst_out_chan", 32'(bus.out_chan), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);

        drive(1'b0, 4'h4, 32'h00A5_0000, 2'd2, 1'b1);
        cycle();
        check("fix_valid", 32'(bus.out_valid), 32'h1);
        check("fix_data", 32'(bus.out_data), 32'hA5);
        check("fix_chan", 32'(bus.out_chan), 32'h2);
`ifndef STREAM_MUX_RR_EN
        drive(1'b0, 4'h4, 32'h00A5_0000, 2'd3, 1'b1);
        #1;
        check("fix_sel_miss", 32'(bus.in_ready), 32'h0);
        cycle();
`endif

        drive(1'b0, 4'h1, 32'h0000_0011, 2'd0, 1'b1);
        cycle();
        check("bp_load", 32'(bus.out_data), 32'h11);
        drive(1'b0, 4'hF, 32'hDDCC_BBAA, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold", 32'(bus.out_data), 32'h11);
            check("bp_ready", 32'(bus.in_ready), 32'h0);
        end
        drive(1'b0, 4'h0, 32'h0, 2'd0, 1'b1);
        cycle();
        check("bp_drained", 32'(bus.out_valid), 32'h0);
        cycle();
        check("bp_once", 32'(bus.out_valid), 32'h0);

        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 4'h1, 32'(i), 2'd0, 1'b1);
            cycle();
            check("stream_valid", 32'(bus.out_valid), 32'h1);
            check("stream_data", 32'(bus.out_data), 32'(i));
        end
        drive(1'b0, 4'h0, 32'h0, 2'd0, 1'b1);
        cycle();

`ifdef STREAM_MUX_RR_EN
        drive(1'b1, 4'h0, 32'h0, 2'd0, 1'b1);
        cycle();
        drive(1'b0, 4'hF, 32'h4433_2211, 2'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_all", 32'(bus.out_chan), 32'(k % 4));
        end
        drive(1'b0, 4'h9, 32'h4433_2211, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_pair", 32'(bus.out_chan), (k % 2 == 1) ? 32'h3 : 32'h0);
        end
        drive(1'b0, 4'h0, 32'h0, 2'd0, 1'b1);
        cycle();
`endif

        drive(1'b0, 4'h1, 32'h0000_003C, 2'd0, 1'b1);
        cycle();
        check("mid_load", 32'(bus.out_data), 32'h3C);
        drive(1'b1, 4'h0, 32'h0, 2'd0, 1'b0);
        cycle();
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        drive(1'b0, 4'h0, 32'h0, 2'd0, 1'b1);
        cycle();
        check("mid_no_3c", 32'(bus.out_valid), 32'h0);
        drive(1'b0, 4'hF, 32'h4433_2211, 2'd0, 1'b1);
        cycle();
        check("mid_ptr_restart", 32'(bus.out_chan), 32'h0);

        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 49) == 0), 4'($urandom), $urandom, 2'($urandom),
                  1'($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
